// File: rtl/sar_adc_sequencer.sv
// rtl/sar_adc_sequencer.sv - periodic SAR ADC conversion sequencer with result FIFO
module sar_adc_sequencer #(
    parameter int BITS         = 8,
    parameter int TRACK_CYCLES = 4,
    parameter int TIMEOUT      = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [15:0]     period,
    input  logic            clr_err,
    output logic            adc_rst_n,
    output logic            adc_start,
    input  logic            adc_out_valid,
    input  logic [BITS-1:0] adc_val,
    output logic [BITS-1:0] sample_data,
    output logic            sample_valid,
    input  logic            sample_ready,
    output logic            busy,
    output logic            overflow,
    output logic            timeout_err
);

    localparam int          AW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT    = (AW+1)'(FIFO_DEPTH);
    localparam logic [15:0] FRAME_LEN   = 16'(TRACK_CYCLES + BITS + 5);
    localparam logic [15:0] TRACK_END   = 16'(TRACK_CYCLES);
    localparam logic [15:0] TIMEOUT_END = 16'(TRACK_CYCLES + TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, ADC_RST, TRACK, START, WAIT, CAPTURE, HOLD
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            tmo_hit;
    logic [15:0]     per_cnt;
    logic [BITS-1:0] cap_val;
    logic            hold_done;

    logic [BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            push;
    logic            pop;
    logic            full;
    logic            accept;

    // per_cnt is zero in ADC_RST, so it also times TRACK and the WAIT timeout.
    assign hold_done = (period == 16'd0) || (period < FRAME_LEN) ||
                       (per_cnt >= period - 16'd1);

    always_comb begin
        state_nxt = state;
        tmo_hit   = 1'b0;
        case (state)
            IDLE:    if (enable) state_nxt = ADC_RST;
            ADC_RST: state_nxt = TRACK;
            TRACK:   if (per_cnt >= TRACK_END) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT: begin
                if (adc_out_valid) begin
                    state_nxt = CAPTURE;
                end else if (per_cnt >= TIMEOUT_END) begin
                    state_nxt = HOLD;
                    tmo_hit   = 1'b1;
                end
            end
            CAPTURE: state_nxt = HOLD;
            HOLD: begin
                if (!enable)        state_nxt = IDLE;
                else if (hold_done) state_nxt = ADC_RST;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            adc_rst_n   <= 1'b0;
            adc_start   <= 1'b0;
            busy        <= 1'b0;
            per_cnt     <= 16'd0;
            cap_val     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            adc_rst_n <= !(state_nxt == IDLE || state_nxt == ADC_RST);
            adc_start <= (state_nxt == START);
            busy      <= (state_nxt != IDLE);
            if (state_nxt == ADC_RST)
                per_cnt <= 16'd0;
            else if (per_cnt != 16'hFFFF)
                per_cnt <= per_cnt + 16'd1;
            if (state == WAIT && adc_out_valid)
                cap_val <= adc_val;
            timeout_err <= tmo_hit | (timeout_err & ~clr_err);
        end
    end

    assign push         = (state == CAPTURE);
    assign sample_valid = (count != '0);
    assign pop          = sample_valid & sample_ready;
    assign full         = (count == FULL_CNT);
    // A pop in the same cycle frees the slot, so a push at full is still taken.
    assign accept       = push & (~full | pop);
    assign sample_data  = sample_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= cap_val;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            overflow <= (push & ~accept) | (overflow & ~clr_err);
        end
    end

endmodule

// File: tb/tb_sar_adc_sequencer.sv
// tb/tb_sar_adc_sequencer.sv - directed-vector bench for sar_adc_sequencer
module tb_sar_adc_sequencer;

    localparam int BITS = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable = 1'b0;
    logic [15:0]     period = 16'd40;
    logic            clr_err = 1'b0;
    logic            adc_rst_n;
    logic            adc_start;
    logic            adc_out_valid = 1'b0;
    logic [BITS-1:0] adc_val = '0;
    logic [BITS-1:0] sample_data;
    logic            sample_valid;
    logic            sample_ready = 1'b0;
    logic            busy;
    logic            overflow;
    logic            timeout_err;

    sar_adc_sequencer #(.BITS(BITS), .TRACK_CYCLES(4), .TIMEOUT(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .period(period), .clr_err(clr_err),
        .adc_rst_n(adc_rst_n), .adc_start(adc_start), .adc_out_valid(adc_out_valid),
        .adc_val(adc_val), .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .busy(busy), .overflow(overflow),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Ideal controller: result valid for one cycle, BITS+1 cycles after adc_start.
    logic            mute = 1'b0;
    logic            inc = 1'b0;
    logic [BITS-1:0] model_val = 8'hA5;
    int              ctr = 0;

    always @(posedge clk) begin
        #1;
        adc_out_valid = 1'b0;
        if (!adc_rst_n) begin
            ctr = 0;
        end else begin
            if (ctr > 0) begin
                ctr--;
                if (ctr == 0 && !mute) begin
                    adc_out_valid = 1'b1;
                    adc_val = model_val;
                    if (inc) model_val++;
                end
            end
            if (adc_start) ctr = BITS + 1;
        end
    end

    logic [BITS-1:0] q[$];

    always @(negedge clk) begin
        #1;
        if (sample_valid && sample_ready) q.push_back(sample_data);
    end

    task automatic wait_start(input string tag, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!adc_start && n < limit);
        check(tag, adc_start, 1);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < limit);
        check(tag, busy, 0);
    endtask

    task automatic clear_flags;
        @(negedge clk) clr_err = 1'b1;
        @(negedge clk) clr_err = 1'b0;
    endtask

    int n;
    int m;
    logic [BITS-1:0] exp_q[$];

    initial begin
        repeat (3) @(negedge clk);
        check("rst_adc_rst_n", adc_rst_n, 0);
        check("rst_adc_start", adc_start, 0);
        check("rst_sample_valid", sample_valid, 0);
        check("rst_sample_data", sample_data, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_timeout_err", timeout_err, 0);
        rst_n = 1'b1;

        // Periodic conversions at period 40, consumer always ready
        sample_ready = 1'b1;
        period = 16'd40;
        model_val = 8'hA5;
        enable = 1'b1;
        wait_start("t1_start0", 20, n);
        check("t1_first_latency", n, 6);
        wait_start("t1_start1", 60, n);
        check("t1_gap1", n, 40);
        wait_start("t1_start2", 60, n);
        check("t1_gap2", n, 40);
        enable = 1'b0;
        wait_idle("t1_idle", 60);
        check("t1_samples", q.size(), 3);
        foreach (q[i]) check("t1_value", q[i], 8'hA5);
        check("t1_idle_adc_rst_n", adc_rst_n, 0);

        // Controller never answers
        q.delete();
        mute = 1'b1;
        enable = 1'b1;
        wait_start("t2_start0", 20, n);
        m = 0;
        do begin
            @(negedge clk);
            m++;
        end while (!timeout_err && m < 40);
        check("t2_timeout_delay", m, 16);
        check("t2_no_sample", sample_valid, 0);
        wait_start("t2_start1", 60, n);
        check("t2_next_frame", n, 24);
        enable = 1'b0;
        wait_idle("t2_idle", 60);
        check("t2_q_empty", q.size(), 0);
        check("t2_err_sticky", timeout_err, 1);
        clear_flags();
        check("t2_err_cleared", timeout_err, 0);

        // Back-to-back frames (period 0) with a stalled consumer
        mute = 1'b0;
        inc = 1'b1;
        model_val = 8'd1;
        sample_ready = 1'b0;
        period = 16'd0;
        enable = 1'b1;
        wait_start("t3_start0", 20, n);
        for (int i = 1; i < 5; i++) begin
            wait_start("t3_start", 40, n);
            check("t3_gap", n, 17);
        end
        enable = 1'b0;
        wait_idle("t3_idle", 40);
        check("t3_overflow", overflow, 1);
        check("t3_valid", sample_valid, 1);
        check("t3_head", sample_data, 1);
        check("t3_adc_rst_n", adc_rst_n, 0);
        clear_flags();
        check("t3_ovf_cleared", overflow, 0);

        // Push and pop in the same cycle while full
        enable = 1'b1;
        wait_start("t4_start", 20, n);
        enable = 1'b0;
        m = 0;
        do begin
            @(negedge clk);
            m++;
        end while (!adc_out_valid && m < 20);
        check("t4_ctrl_valid", adc_out_valid, 1);
        @(negedge clk) sample_ready = 1'b1;
        @(negedge clk) sample_ready = 1'b0;
        check("t4_no_overflow", overflow, 0);
        check("t4_head", sample_data, 2);
        wait_idle("t4_idle", 20);
        sample_ready = 1'b1;
        repeat (6) @(negedge clk);
        sample_ready = 1'b0;
        exp_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd6};
        check("t4_drained", q.size(), 5);
        foreach (exp_q[i]) if (i < q.size()) check("t4_order", q[i], exp_q[i]);
        check("t4_empty", sample_valid, 0);

        // Reset during WAIT abandons the frame
        q.delete();
        inc = 1'b0;
        model_val = 8'h3C;
        period = 16'd40;
        sample_ready = 1'b1;
        enable = 1'b1;
        wait_start("t5_start", 20, n);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        check("t5_adc_rst_n", adc_rst_n, 0);
        check("t5_adc_start", adc_start, 0);
        check("t5_busy", busy, 0);
        check("t5_valid", sample_valid, 0);
        check("t5_overflow", overflow, 0);
        check("t5_timeout_err", timeout_err, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t5_no_sample", q.size(), 0);
        check("t5_still_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sar_adc_sequencer.md
SAR_ADC_SEQUENCER -- requirements
Module: sar_adc_sequencer

Interface
REQ-001 SHALL have parameter BITS, default 8, sample width matching the SAR controller.
REQ-002 SHALL have parameter TRACK_CYCLES, default 4, cycles the controller is held in sampling before adc_start.
REQ-003 SHALL have parameter TIMEOUT, default 16, max cycles from adc_start to adc_out_valid.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, result FIFO entries, power of two.
REQ-005 SHALL have ports: clk  in  1  clock; single clock domain, all logic on rising edge.
REQ-006 SHALL have ports: rst_n  in  1  reset; synchronous, active-low.
REQ-007 SHALL have ports: enable  in  1  continuous conversion while high.
REQ-008 SHALL have ports: period  in  16  cycles between conversion starts.
REQ-009 SHALL have ports: clr_err  in  1  clears sticky flags.
REQ-010 SHALL have ports: adc_rst_n  out  1  drives controller rst_n.
REQ-011 SHALL have ports: adc_start  out  1  drives controller adc_start.
REQ-012 SHALL have ports: adc_out_valid  in  1  controller out_valid.
REQ-013 SHALL have ports: adc_val  in  BITS  controller result.
REQ-014 SHALL have ports: sample_data  out  BITS  FIFO head.
REQ-015 SHALL have ports: sample_valid  out  1  FIFO non-empty.
REQ-016 SHALL have ports: sample_ready  in  1  consumer accept.
REQ-017 SHALL have ports: busy  out  1  state != IDLE.
REQ-018 SHALL have ports: overflow  out  1  sticky; sample dropped.
REQ-019 SHALL have ports: timeout_err  out  1  sticky; conversion timed out.

Function
REQ-020 SHALL implement FSM states IDLE, ADC_RST, TRACK, START, WAIT, CAPTURE, HOLD.
REQ-021 SHALL transition IDLE->ADC_RST when enable=1.
REQ-022 SHALL drive adc_rst_n=0 for exactly one cycle in ADC_RST, then go to TRACK.
REQ-023 SHALL hold adc_rst_n=1, adc_start=0 in TRACK for TRACK_CYCLES cycles, then go to START.
REQ-024 SHALL drive adc_start=1 for exactly one cycle in START, then go to WAIT; adc_start=0 in all other states.
REQ-025 SHALL, in WAIT, go to CAPTURE on the first cycle adc_out_valid=1, registering adc_val that cycle.
REQ-026 SHALL, in WAIT, count cycles after START; at count TIMEOUT without adc_out_valid, set timeout_err, push nothing, go to HOLD.
REQ-027 SHALL, in CAPTURE, push registered value into FIFO (one cycle), then go to HOLD.
REQ-028 SHALL run a 16-bit period counter cleared on ADC_RST entry, incrementing every cycle.
REQ-029 SHALL, in HOLD, go to ADC_RST when enable=1 and counter >= period-1; go to IDLE when enable=0.
REQ-030 SHALL treat period smaller than frame length (TRACK_CYCLES+BITS+5) or 0 as back-to-back: HOLD exits after one cycle.
REQ-031 SHALL, on enable deasserted mid-frame, complete the current frame (capture or timeout) before IDLE.
REQ-032 SHALL keep adc_rst_n=0 in IDLE (controller held off).
REQ-033 SHALL, with FIFO full and no pop that cycle, drop the push and set overflow; push with simultaneous pop at full is accepted.
REQ-034 SHALL pop on sample_valid & sample_ready; sample_data SHALL present oldest entry; pointers wrap modulo FIFO_DEPTH.
REQ-035 SHALL, on clr_err=1, clear overflow and timeout_err; a same-cycle set event SHALL win.

Reset
REQ-036 SHALL, on rst_n=0 at clk edge: state IDLE, adc_rst_n=0, adc_start=0, FIFO empty, sample_valid=0, sample_data=0, busy=0, overflow=0, timeout_err=0, counters 0.
REQ-037 SHALL, on reset mid-frame, abandon the frame with no push and no flag change other than clearing.

Verification
REQ-038 SHALL test: enable=1, period=40, ideal controller model, adc_val=0xA5 -> adc_start pulses 40 cycles apart, FIFO yields 0xA5 each frame.
REQ-039 SHALL test: adc_out_valid never asserted -> timeout_err=1 exactly 16 cycles after adc_start, no sample pushed, next frame still issued.
REQ-040 SHALL test: sample_ready=0, 5 conversions -> 4 entries retained in order, overflow=1; clr_err clears it.
REQ-041 SHALL test: FIFO full, push and pop same cycle -> no overflow, count stays 4.
REQ-042 SHALL test: period=0 -> ADC_RST follows CAPTURE after one HOLD cycle; enable drop in WAIT -> capture then IDLE, adc_rst_n=0.
REQ-043 SHALL test: rst_n=0 during WAIT -> all outputs at reset values next cycle, no sample delivered.
